// File: rtl/vend_pkg.sv
// Shared state encoding and admin menu indices for the vending mode controller
// and the display decoder.
package vend_pkg;

  localparam int VEND_ST_W = 5;
  typedef logic [VEND_ST_W-1:0] vend_st_t;

  localparam vend_st_t ST_OFF         = 5'd0;
  localparam vend_st_t ST_WELCOME     = 5'd1;
  localparam vend_st_t ST_INQUIRE     = 5'd2;
  localparam vend_st_t ST_ADD_AMOUNT  = 5'd3;
  localparam vend_st_t ST_PAYMENT     = 5'd4;
  localparam vend_st_t ST_SUCCESS     = 5'd5;
  localparam vend_st_t ST_FAILURE     = 5'd6;
  localparam vend_st_t ST_SOLD_OUT    = 5'd7;
  localparam vend_st_t ST_ADM_MENU    = 5'd8;
  localparam vend_st_t ST_ADM_INQUIRE = 5'd9;
  localparam vend_st_t ST_ADM_ADD     = 5'd10;
  localparam vend_st_t ST_ADM_RESET   = 5'd11;
  localparam vend_st_t ST_ADM_SALE    = 5'd12;

  localparam int ADM_IDX_INQUIRE = 0;
  localparam int ADM_IDX_RESET   = 1;
  localparam int ADM_IDX_SALE    = 2;

  function automatic logic is_user_st(input vend_st_t s);
    return (s >= ST_WELCOME) && (s <= ST_SOLD_OUT);
  endfunction

  function automatic logic is_admin_st(input vend_st_t s);
    return (s >= ST_ADM_MENU) && (s <= ST_ADM_SALE);
  endfunction

  // States that leave on their own after a fixed message time
  function automatic logic is_msg_st(input vend_st_t s);
    return (s == ST_WELCOME) || (s == ST_SUCCESS) || (s == ST_FAILURE) ||
           (s == ST_SOLD_OUT) || (s == ST_ADM_RESET) || (s == ST_ADM_SALE);
  endfunction

  function automatic logic is_idle_st(input vend_st_t s);
    return (s == ST_ADD_AMOUNT) || (s == ST_PAYMENT);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic ev_o
);

  logic btn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= 1'b0;
    else        btn_q <= btn_i;
  end

  assign ev_o = btn_i & ~btn_q;

endmodule

// File: rtl/vend_mode_ctrl.sv
// Operating-mode FSM for the vending machine: user flow, admin menu, message
// and idle timers on one shared down-counter.
//  state        | meaning
//  OFF          | power switch off
//  WELCOME      | timed splash after power-on
//  INQUIRE      | browsing products
//  ADD_AMOUNT   | entering quantity (idle timeout)
//  PAYMENT      | waiting for payment block (idle timeout)
//  SUCCESS      | timed: product vended
//  FAILURE      | timed: payment refused/abandoned
//  SOLD_OUT     | timed: selected product empty
//  ADM_MENU     | admin entry selection
//  ADM_INQUIRE  | admin stock view
//  ADM_ADD      | admin restock
//  ADM_RESET    | timed: stock reset requested
//  ADM_SALE     | timed: sales report
module vend_mode_ctrl
  import vend_pkg::*;
#(
  parameter int N_ADM    = 3,
  parameter int MSG_CYC  = 150_000_000,
  parameter int IDLE_CYC = 500_000_000,
  parameter int ST_W     = VEND_ST_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     main_switch,
  input  logic                     adm_mode,
  input  logic                     btn_plus,
  input  logic                     btn_minus,
  input  logic                     btn_confirm,
  input  logic                     btn_return,
  input  logic                     pay_ok,
  input  logic                     pay_fail,
  input  logic                     stock_empty,
  output logic [ST_W-1:0]          state,
  output logic [$clog2(N_ADM)-1:0] adm_sel,
  output logic                     reset_req,
  output logic                     vend_pulse
);

  localparam int SEL_W   = $clog2(N_ADM);
  localparam int TMR_MAX = (MSG_CYC > IDLE_CYC) ? MSG_CYC : IDLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_ADM - 1);
  // Loaded one short so a state is held for exactly MSG_CYC/IDLE_CYC cycles
  localparam logic [TMR_W-1:0] MSG_LD  = TMR_W'(MSG_CYC - 1);
  localparam logic [TMR_W-1:0] IDLE_LD = TMR_W'(IDLE_CYC - 1);

  logic ev_plus, ev_minus, ev_confirm, ev_return;
  logic any_ev, conf, tmo;

  vend_st_t           state_q, state_d;
  logic [SEL_W-1:0]   adm_sel_q, adm_sel_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               reset_req_q, reset_req_d;
  logic               vend_pulse_q, vend_pulse_d;

  btn_edge u_edge_plus    (.clk(clk), .rst_n(rst_n), .btn_i(btn_plus),    .ev_o(ev_plus));
  btn_edge u_edge_minus   (.clk(clk), .rst_n(rst_n), .btn_i(btn_minus),   .ev_o(ev_minus));
  btn_edge u_edge_confirm (.clk(clk), .rst_n(rst_n), .btn_i(btn_confirm), .ev_o(ev_confirm));
  btn_edge u_edge_return  (.clk(clk), .rst_n(rst_n), .btn_i(btn_return),  .ev_o(ev_return));

  assign any_ev = ev_plus | ev_minus | ev_confirm | ev_return;
  assign conf   = ev_confirm & ~ev_return;
  assign tmo    = (tmr_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      adm_sel_q    <= '0;
      tmr_q        <= '0;
      reset_req_q  <= 1'b0;
      vend_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      adm_sel_q    <= adm_sel_d;
      tmr_q        <= tmr_d;
      reset_req_q  <= reset_req_d;
      vend_pulse_q <= vend_pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:        if (main_switch) state_d = ST_WELCOME;
      ST_WELCOME:    if (tmo || ev_confirm || ev_return) state_d = ST_INQUIRE;
      ST_INQUIRE:    if (conf) state_d = stock_empty ? ST_SOLD_OUT : ST_ADD_AMOUNT;
      ST_ADD_AMOUNT: begin
        if (ev_return)  state_d = ST_INQUIRE;
        else if (conf)  state_d = ST_PAYMENT;
        else if (tmo)   state_d = ST_INQUIRE;
      end
      ST_PAYMENT: begin
        if (pay_ok)                            state_d = ST_SUCCESS;
        else if (pay_fail || ev_return || tmo) state_d = ST_FAILURE;
      end
      ST_SUCCESS, ST_FAILURE, ST_SOLD_OUT:
        if (tmo || ev_confirm || ev_return) state_d = ST_INQUIRE;
      ST_ADM_MENU: begin
        if (conf) begin
          if (adm_sel_q == SEL_W'(ADM_IDX_INQUIRE))    state_d = ST_ADM_INQUIRE;
          else if (adm_sel_q == SEL_W'(ADM_IDX_RESET)) state_d = ST_ADM_RESET;
          else                                         state_d = ST_ADM_SALE;
        end
      end
      ST_ADM_INQUIRE: begin
        if (ev_return)  state_d = ST_ADM_MENU;
        else if (conf)  state_d = ST_ADM_ADD;
      end
      ST_ADM_ADD:    if (ev_return) state_d = ST_ADM_INQUIRE;
      ST_ADM_RESET, ST_ADM_SALE:
        if (tmo || ev_confirm || ev_return) state_d = ST_ADM_MENU;
      default:       state_d = ST_OFF;
    endcase
    if (is_user_st(state_q) && adm_mode)   state_d = ST_ADM_MENU;
    if (is_admin_st(state_q) && !adm_mode) state_d = ST_INQUIRE;
    if (!main_switch)                      state_d = ST_OFF;
  end

  always_comb begin
    adm_sel_d = adm_sel_q;
    if (is_user_st(state_q) && (state_d == ST_ADM_MENU)) begin
      adm_sel_d = '0;
    end else if ((state_q == ST_ADM_MENU) && (state_d == ST_ADM_MENU)) begin
      if (ev_plus && !ev_minus)
        adm_sel_d = (adm_sel_q == SEL_LAST) ? '0 : adm_sel_q + SEL_W'(1);
      else if (ev_minus && !ev_plus)
        adm_sel_d = (adm_sel_q == '0) ? SEL_LAST : adm_sel_q - SEL_W'(1);
    end
  end

  always_comb begin
    tmr_d = tmr_q;
    if (state_d != state_q) begin
      if (is_msg_st(state_d))       tmr_d = MSG_LD;
      else if (is_idle_st(state_d)) tmr_d = IDLE_LD;
      else                          tmr_d = '0;
    end else if (is_idle_st(state_q) && any_ev) begin
      tmr_d = IDLE_LD;
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - TMR_W'(1);
    end
  end

  always_comb begin
    reset_req_d  = (state_d == ST_ADM_RESET) && (state_q != ST_ADM_RESET);
    vend_pulse_d = (state_d == ST_SUCCESS)   && (state_q != ST_SUCCESS);
  end

  assign state      = ST_W'(state_q);
  assign adm_sel    = adm_sel_q;
  assign reset_req  = reset_req_q;
  assign vend_pulse = vend_pulse_q;

endmodule

// File: tb/tb_vend_mode_ctrl.sv
// Directed bench for vend_mode_ctrl: a 3-entry and a 5-entry admin build run
// side by side on the same stimulus.
module tb_vend_mode_ctrl;
  import vend_pkg::*;

  localparam int B_PLUS = 0, B_MINUS = 1, B_CONF = 2, B_RET = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic main_switch = 1'b0, adm_mode = 1'b0;
  logic btn_plus = 1'b0, btn_minus = 1'b0, btn_confirm = 1'b0, btn_return = 1'b0;
  logic pay_ok = 1'b0, pay_fail = 1'b0, stock_empty = 1'b0;

  logic [4:0] st3, st5;
  logic [1:0] sel3;
  logic [2:0] sel5;
  logic       rr3, vp3, rr5, vp5;

  int n_tests = 0;
  int n_fail  = 0;
  int n, pulses;

  always #5 clk = ~clk;

  vend_mode_ctrl #(.N_ADM(3), .MSG_CYC(8), .IDLE_CYC(20), .ST_W(5)) dut3 (
    .clk(clk), .rst_n(rst_n), .main_switch(main_switch), .adm_mode(adm_mode),
    .btn_plus(btn_plus), .btn_minus(btn_minus), .btn_confirm(btn_confirm),
    .btn_return(btn_return), .pay_ok(pay_ok), .pay_fail(pay_fail),
    .stock_empty(stock_empty), .state(st3), .adm_sel(sel3),
    .reset_req(rr3), .vend_pulse(vp3));

  vend_mode_ctrl #(.N_ADM(5), .MSG_CYC(8), .IDLE_CYC(20), .ST_W(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .main_switch(main_switch), .adm_mode(adm_mode),
    .btn_plus(btn_plus), .btn_minus(btn_minus), .btn_confirm(btn_confirm),
    .btn_return(btn_return), .pay_ok(pay_ok), .pay_fail(pay_fail),
    .stock_empty(stock_empty), .state(st5), .adm_sel(sel5),
    .reset_req(rr5), .vend_pulse(vp5));

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_PLUS:  btn_plus    = v;
      B_MINUS: btn_minus   = v;
      B_CONF:  btn_confirm = v;
      default: btn_return  = v;
    endcase
  endtask

  // Press for one cycle, release for one cycle so the next press is a fresh edge
  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick();
    set_btn(b, 1'b0);
    tick();
  endtask

  // Count cycles until the DUT leaves state s; pulses sums both pulse outputs meanwhile
  task automatic hold(input logic [4:0] s, output int cnt, output int pul);
    cnt = 0;
    pul = 0;
    while (st3 == s && cnt < 60) begin
      tick();
      cnt++;
      pul += int'(vp3) + int'(rr3);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    chk("rst_state", st3, ST_OFF);
    chk("rst_sel3", sel3, 0);
    chk("rst_sel5", sel5, 0);
    chk("rst_rr", rr3, 0);
    chk("rst_vp", vp3, 0);
    rst_n = 1'b1;
    tick();
    chk("off_hold", st3, ST_OFF);

    main_switch = 1'b1;
    tick();
    chk("welcome_entry", st3, ST_WELCOME);
    hold(ST_WELCOME, n, pulses);
    chk("welcome_len", n, 8);
    chk("welcome_exit", st3, ST_INQUIRE);

    main_switch = 1'b0;
    tick();
    chk("sw_off", st3, ST_OFF);
    main_switch = 1'b1;
    tick(); tick(); tick();
    chk("welcome_c2", st3, ST_WELCOME);
    press(B_CONF);
    chk("welcome_early", st3, ST_INQUIRE);

    btn_confirm = 1'b1; btn_return = 1'b1;
    tick();
    btn_confirm = 1'b0; btn_return = 1'b0;
    tick();
    chk("conf_ret_ret_wins", st3, ST_INQUIRE);

    press(B_CONF);
    chk("to_add", st3, ST_ADD_AMOUNT);
    press(B_RET);
    chk("add_ret", st3, ST_INQUIRE);
    press(B_CONF);
    press(B_CONF);
    chk("to_pay", st3, ST_PAYMENT);
    pay_ok = 1'b1;
    tick();
    pay_ok = 1'b0;
    chk("to_success", st3, ST_SUCCESS);
    chk("vend_pulse", vp3, 1);
    hold(ST_SUCCESS, n, pulses);
    chk("success_len", n, 8);
    chk("vend_single", pulses, 0);
    chk("success_exit", st3, ST_INQUIRE);

    press(B_CONF);
    press(B_CONF);
    hold(ST_PAYMENT, n, pulses);
    chk("idle_len", n + 1, 20);
    chk("idle_fail", st3, ST_FAILURE);
    press(B_RET);
    chk("fail_ret", st3, ST_INQUIRE);

    press(B_CONF);
    press(B_CONF);
    repeat (10) tick();
    press(B_PLUS);
    chk("idle_reload_st", st3, ST_PAYMENT);
    hold(ST_PAYMENT, n, pulses);
    chk("idle_reload_len", n + 1, 20);
    press(B_CONF);
    chk("fail_conf", st3, ST_INQUIRE);

    press(B_CONF);
    press(B_CONF);
    pay_ok = 1'b1; btn_return = 1'b1;
    tick();
    pay_ok = 1'b0; btn_return = 1'b0;
    chk("ok_beats_ret", st3, ST_SUCCESS);
    tick();
    press(B_RET);
    chk("success_ret", st3, ST_INQUIRE);

    press(B_CONF);
    press(B_CONF);
    adm_mode = 1'b1;
    tick();
    chk("adm_entry", st3, ST_ADM_MENU);
    chk("adm_sel0", sel3, 0);
    press(B_MINUS);
    chk("wrap_dn3", sel3, 2);
    chk("wrap_dn5", sel5, 4);
    press(B_PLUS);
    chk("wrap_up3", sel3, 0);
    chk("wrap_up5", sel5, 0);
    btn_plus = 1'b1; btn_minus = 1'b1;
    tick();
    btn_plus = 1'b0; btn_minus = 1'b0;
    tick();
    chk("plus_minus", sel3, 0);
    press(B_PLUS);
    chk("sel1", sel3, 1);
    btn_confirm = 1'b1;
    tick();
    btn_confirm = 1'b0;
    chk("adm_reset", st3, ST_ADM_RESET);
    chk("reset_req", rr3, 1);
    hold(ST_ADM_RESET, n, pulses);
    chk("adm_reset_len", n, 8);
    chk("reset_single", pulses, 0);
    chk("adm_reset_exit", st3, ST_ADM_MENU);
    chk("sel_kept", sel3, 1);

    press(B_MINUS);
    press(B_CONF);
    chk("adm_inq", st3, ST_ADM_INQUIRE);
    press(B_CONF);
    chk("adm_add", st3, ST_ADM_ADD);
    press(B_RET);
    chk("add_back", st3, ST_ADM_INQUIRE);
    press(B_RET);
    chk("inq_back", st3, ST_ADM_MENU);

    press(B_MINUS);
    press(B_MINUS);
    chk("sel5_3", sel5, 3);
    press(B_CONF);
    chk("dut3_sel1_reset", st3, ST_ADM_RESET);
    chk("dut5_sel3_sale", st5, ST_ADM_SALE);

    adm_mode = 1'b0;
    tick();
    chk("adm_leave", st3, ST_INQUIRE);
    adm_mode = 1'b1;
    tick();
    chk("adm_reenter_sel3", sel3, 0);
    chk("adm_reenter_sel5", sel5, 0);
    adm_mode = 1'b0;
    tick();

    stock_empty = 1'b1;
    press(B_CONF);
    chk("sold_out", st3, ST_SOLD_OUT);
    hold(ST_SOLD_OUT, n, pulses);
    chk("sold_out_len", n + 1, 8);
    chk("sold_out_exit", st3, ST_INQUIRE);
    stock_empty = 1'b0;

    press(B_CONF);
    press(B_CONF);
    main_switch = 1'b0; pay_ok = 1'b1;
    tick();
    pay_ok = 1'b0;
    chk("pay_drop_off", st3, ST_OFF);
    chk("pay_drop_novend", vp3, 0);

    main_switch = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", st3, ST_OFF);
    tick();
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
